// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with its own HI/LO register pair
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   start  launches op (00 mult, 01 multu, 10 div, 11 divu) on srca/srcb; sampled only when idle
//   flush  cancels an in-flight operation (or a same-cycle start)
//   wrhi/wrlo/wdata  mthi/mtlo writes, honoured only when idle
//   busy   high while an operation is in flight; done pulses one cycle when hi/lo take a result
//   hi/lo  HI/LO registers
// Optional: define MDU_EARLY_TERM_EN to let multiplies finish once the remaining multiplier bits are zero.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             wrhi,
  input  logic             wrlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
`ifdef MDU_EARLY_TERM_EN
  localparam bit earlyTerm = 1'b1;
`else
  localparam bit earlyTerm = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;
  stateT state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] bReg;
  logic [CNTW-1:0] cnt;
  logic isDiv, negRes, negRem;
  logic sa, sb;
  logic [WIDTH-1:0] magA, magB, quo, rem, quoFix, remFix, remMask;
  logic [WIDTH:0] mulSum, remShift, diff;
  logic [2*WIDTH-1:0] mulNext, mulAligned, divNext, prod;
  logic lastIter, mulDone, startZero;
  assign busy = state != IDLE;
  always_comb begin
    sa = ~op[0] & srca[WIDTH-1];
    sb = ~op[0] & srcb[WIDTH-1];
    magA = sa ? -srca : srca;
    magB = sb ? -srcb : srcb;
    // multiply step: add multiplicand into the upper half, keeping the carry, then shift right
    mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? bReg : {WIDTH{1'b0}}};
    mulNext = {mulSum, acc[WIDTH-1:1]};
    // restoring divide step on a WIDTH+1 bit partial remainder; diff[WIDTH] set means the trial went negative
    remShift = acc[2*WIDTH-1:WIDTH-1];
    diff = remShift - {1'b0, bReg};
    divNext = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    lastIter = cnt == CNTW'(WIDTH - 1);
    // unconsumed multiplier bits after this step sit below the product bits already shifted in
    remMask = {WIDTH{1'b1}} >> ({1'b0, cnt} + 1'b1);
    mulDone = (mulNext[WIDTH-1:0] & remMask) == '0;
    mulAligned = mulNext >> (CNTW'(WIDTH - 1) - cnt);
    startZero = ~op[1] & (magB == '0);
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
    prod = negRes ? -acc : acc;
    // divide by zero leaves the dividend as remainder and forces an all-ones quotient
    quoFix = (bReg == '0) ? {WIDTH{1'b1}} : negRes ? -quo : quo;
    remFix = negRem ? -rem : rem;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc <= '0;
      bReg <= '0;
      cnt <= '0;
      isDiv <= 1'b0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wrhi) hi <= wdata;
          if (wrlo) lo <= wdata;
          if (start && !flush) begin
            state <= (earlyTerm && startZero) ? FIX : CALC;
            acc <= {{WIDTH{1'b0}}, op[1] ? magA : magB};
            bReg <= op[1] ? magB : magA;
            isDiv <= op[1];
            negRes <= sa ^ sb;
            negRem <= sa;
            cnt <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (flush) state <= IDLE;
          else if (isDiv) begin
            acc <= divNext;
            if (lastIter) state <= FIX;
          end else if (lastIter || (earlyTerm && mulDone)) begin
            acc <= mulAligned;
            state <= FIX;
          end else acc <= mulNext;
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            {hi, lo} <= isDiv ? {remFix, quoFix} : prod;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
